frame_tx: RTL and testbench
===========================

FRAME_TX -- requirements
Module: frame_tx

Interface
REQ-001 SHALL have parameter LEN_BITS, default 8, width of the response-length FIFO entry (payload byte count).
REQ-002 SHALL have parameter MAX_PAYLOAD, default 59, largest payload byte count sent in one frame (64-byte frame limit).
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 len_fifo_data  input  LEN_BITS  payload byte count of the next response; valid while len_fifo_empty=0 (first-word-fall-through).
REQ-006 len_fifo_empty  input  1  length FIFO has no entry.
REQ-007 len_fifo_rd_en  output  1  one-cycle pop of the length FIFO.
REQ-008 ring_data  input  8  next payload byte; valid while ring_empty=0 (first-word-fall-through).
REQ-009 ring_empty  input  1  payload ring has no byte.
REQ-010 ring_rd_en  output  1  one-cycle pop of the payload ring.
REQ-011 seq_in  input  4  current receive sequence number to acknowledge.
REQ-012 ack_req  input  1  one-cycle pulse requesting an acknowledge frame.
REQ-013 tx_data  output  8  frame byte to the UART transmitter.
REQ-014 tx_valid  output  1  tx_data is valid.
REQ-015 tx_ready  input  1  transmitter accepts tx_data this cycle.
REQ-016 overflow_err  output  1  one-cycle pulse when an oversize response is discarded.

Function
REQ-017 Frame format SHALL be: LEN, SEQ, payload[0..n-1], CRC_HI, CRC_LO, SYNC; LEN=n+5; SEQ={4'h1, seq_in}; SYNC=8'h7E.
REQ-018 States SHALL be IDLE, LEN, SEQ, PAYLOAD, CRC_HI, CRC_LO, SYNC, DISCARD.
REQ-019 IDLE: if len_fifo_empty=0, pop length (len_fifo_rd_en=1), latch n, clear pending ack, go LEN (or DISCARD if n>MAX_PAYLOAD); else if ack pending, clear it, latch n=0, go LEN.
REQ-020 seq_in SHALL be sampled once on leaving IDLE and held for the frame.
REQ-021 A byte transfers only on tx_valid&tx_ready; tx_data SHALL stay stable while tx_valid=1 and tx_ready=0.
REQ-022 LEN->SEQ->PAYLOAD (SEQ->CRC_HI when n=0); PAYLOAD->CRC_HI after n-th transfer; CRC_HI->CRC_LO->SYNC->IDLE.
REQ-023 PAYLOAD: tx_valid=!ring_empty, tx_data=ring_data; ring_rd_en=1 in the cycle a payload byte transfers; ring empty stalls with tx_valid=0.
REQ-024 CRC SHALL be CRC-16-CCITT in the serial-protocol byte form, init 16'hFFFF, over LEN, SEQ and payload, updated one byte per transfer; CRC_HI=crc[15:8], CRC_LO=crc[7:0].
REQ-025 Per byte b: d=b^crc[7:0]; d=d^(d<<4) truncated to 8 bits; crc={d,crc[15:8]}^(d>>4)^(d<<3).
REQ-026 DISCARD: pop n ring bytes (one per cycle while ring_empty=0), no tx output, pulse overflow_err once on entry, then IDLE.
REQ-027 ack_req while a frame is in progress SHALL set the pending flag; a following frame start clears it (every frame carries SEQ).
REQ-028 ack_req in the same cycle IDLE pops a length entry SHALL leave ack pending.
REQ-029 Back-to-back frames: IDLE SHALL last exactly one cycle when work is pending; minimum frame time n+6 cycles with tx_ready=1.

Reset
REQ-030 On rst: state IDLE, tx_valid=0, tx_data=0, len_fifo_rd_en=0, ring_rd_en=0, overflow_err=0, ack pending=0, crc=16'hFFFF.
REQ-031 Reset mid-frame SHALL abandon the frame; already popped bytes are lost; no partial frame resumes.

Configuration
REQ-032 Macro FRAME_TX_STATS_EN: when defined, adds output frame_count [15:0], reset 0, incremented on each SYNC transfer, wrapping 16'hFFFF->0; when undefined the port and counter are absent, all other behaviour identical.

Verification
REQ-033 Ack: seq_in=0, ack_req pulse, tx_ready=1 -> bytes 05 10 9E 81 7E, no ring/len pops.
REQ-034 Response: length entry 3, ring AA BB CC, seq_in=5 -> LEN=08, SEQ=15, AA BB CC, CRC per REQ-025 against reference model, 7E; one len pop, three ring pops.
REQ-035 Backpressure: same as REQ-034 with tx_ready toggling every cycle -> identical byte sequence, tx_data stable during stalls.
REQ-036 Underflow: length 2, ring delivers second byte 10 cycles late -> tx_valid=0 during gap, frame correct.
REQ-037 Oversize: length 60, 60 ring bytes -> no tx bytes, 60 ring pops, one overflow_err pulse, then next queued frame sent normally.
REQ-038 Reset during PAYLOAD of a 3-byte frame -> outputs return to reset values immediately; next ack_req yields a clean 05 1x .. .. 7E frame.

Source files
------------

// File: rtl/frame_tx_if.sv
// frame_tx_if: the data-side connections of the frame transmitter.
//
// Groups the three streams that frame_tx talks to:
//   length FIFO  : len_fifo_data, len_fifo_empty (first-word-fall-through), len_fifo_rd_en pop
//   payload ring : ring_data, ring_empty (first-word-fall-through), ring_rd_en pop
//   transmitter  : tx_data, tx_valid, tx_ready
//
// Modports:
//   master : the frame transmitter side (pops the FIFO/ring, drives tx_data/tx_valid)
//   slave  : the FIFO/ring/UART side
interface frame_tx_if #(
  parameter int LEN_BITS = 8
);
  logic [LEN_BITS-1:0] len_fifo_data;
  logic                len_fifo_empty;
  logic                len_fifo_rd_en;
  logic [7:0]          ring_data;
  logic                ring_empty;
  logic                ring_rd_en;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                tx_ready;

  modport master (
    input  len_fifo_data, len_fifo_empty,
    output len_fifo_rd_en,
    input  ring_data, ring_empty,
    output ring_rd_en,
    output tx_data, tx_valid,
    input  tx_ready
  );

  modport slave (
    output len_fifo_data, len_fifo_empty,
    input  len_fifo_rd_en,
    output ring_data, ring_empty,
    input  ring_rd_en,
    input  tx_data, tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/frame_tx.sv
// frame_tx: builds response and acknowledge frames for the UART transmitter.
//
// Frame: LEN, SEQ, payload[0..n-1], CRC_HI, CRC_LO, SYNC
//   LEN = n+5, SEQ = {4'h1, seq_in}, SYNC = 8'h7E,
//   CRC-16-CCITT (byte form, init 16'hFFFF) over LEN, SEQ and payload.
// Responses whose length exceeds MAX_PAYLOAD are drained from the ring
// without any transmit output and flagged with a one-cycle overflow_err.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   bus (master)  : length FIFO, payload ring and transmitter streams
//   seq_in        : receive sequence number, sampled when a frame starts
//   ack_req       : one-cycle pulse requesting an acknowledge frame
//   overflow_err  : one-cycle pulse when an oversize response is discarded
//   frame_count   : (only with FRAME_TX_STATS_EN) frames completed, wrapping
//
// Optional feature macro: FRAME_TX_STATS_EN adds the frame_count output.
module frame_tx #(
  parameter int LEN_BITS    = 8,
  parameter int MAX_PAYLOAD = 59
) (
  input  logic        clk,
  input  logic        rst,
  frame_tx_if.master  bus,
  input  logic [3:0]  seq_in,
  input  logic        ack_req,
  output logic        overflow_err
`ifdef FRAME_TX_STATS_EN
  ,
  output logic [15:0] frame_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_SEQ,
    S_PAYLOAD,
    S_CRC_HI,
    S_CRC_LO,
    S_SYNC,
    S_DISCARD
  } state_t;

  state_t              state;
  state_t              state_n;
  logic [LEN_BITS-1:0] n_reg;
  logic [LEN_BITS-1:0] cnt;
  logic [3:0]          seq_reg;
  logic [15:0]         crc;
  logic                ack_pend;

  logic                start;
  logic                len_pop;
  logic                tx_valid_c;
  logic [7:0]          tx_data_c;
  logic                ring_rd_c;
  logic                fire;
  logic                last_byte;
  logic [7:0]          len_byte;

  // One CRC-16-CCITT step in the serial-protocol byte form.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
    logic [7:0] d;
    d = b ^ c[7:0];
    d = d ^ (d << 4);
    crc_step = {d, c[15:8]} ^ {12'h000, d[7:4]} ^ {5'b00000, d, 3'b000};
  endfunction

  assign fire      = tx_valid_c & bus.tx_ready;
  assign last_byte = (cnt == n_reg - LEN_BITS'(1));
  assign len_byte  = 8'(n_reg) + 8'd5;

  assign bus.tx_valid       = tx_valid_c;
  assign bus.tx_data        = tx_data_c;
  assign bus.ring_rd_en     = ring_rd_c;
  assign bus.len_fifo_rd_en = len_pop;

  // Next-state and output decode. The length pop is also gated by rst so a
  // waiting FIFO entry is not consumed while the block is held in reset.
  always_comb begin
    state_n    = state;
    tx_valid_c = 1'b0;
    tx_data_c  = 8'h00;
    ring_rd_c  = 1'b0;
    len_pop    = 1'b0;
    start      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!bus.len_fifo_empty && !rst) begin
          len_pop = 1'b1;
          start   = 1'b1;
          if (bus.len_fifo_data > LEN_BITS'(MAX_PAYLOAD)) begin
            state_n = S_DISCARD;
          end else begin
            state_n = S_LEN;
          end
        end else if (ack_pend) begin
          start   = 1'b1;
          state_n = S_LEN;
        end
      end
      S_LEN: begin
        tx_valid_c = 1'b1;
        tx_data_c  = len_byte;
        if (bus.tx_ready) state_n = S_SEQ;
      end
      S_SEQ: begin
        tx_valid_c = 1'b1;
        tx_data_c  = {4'h1, seq_reg};
        if (bus.tx_ready) begin
          state_n = (n_reg == '0) ? S_CRC_HI : S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        tx_valid_c = !bus.ring_empty;
        tx_data_c  = bus.ring_data;
        if (fire) begin
          ring_rd_c = 1'b1;
          if (last_byte) state_n = S_CRC_HI;
        end
      end
      S_CRC_HI: begin
        tx_valid_c = 1'b1;
        tx_data_c  = crc[15:8];
        if (bus.tx_ready) state_n = S_CRC_LO;
      end
      S_CRC_LO: begin
        tx_valid_c = 1'b1;
        tx_data_c  = crc[7:0];
        if (bus.tx_ready) state_n = S_SYNC;
      end
      S_SYNC: begin
        tx_valid_c = 1'b1;
        tx_data_c  = 8'h7E;
        if (bus.tx_ready) state_n = S_IDLE;
      end
      S_DISCARD: begin
        if (!bus.ring_empty) begin
          ring_rd_c = 1'b1;
          if (last_byte) state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Frame context: length, sequence and CRC are captured at frame start and
  // the CRC then advances on every LEN/SEQ/payload transfer. An ack_req in
  // the start cycle wins over the clear, so it is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      n_reg        <= '0;
      cnt          <= '0;
      seq_reg      <= 4'h0;
      crc          <= 16'hFFFF;
      ack_pend     <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      state        <= state_n;
      overflow_err <= start && (state_n == S_DISCARD);
      ack_pend     <= ack_req | (ack_pend & ~start);
      if (start) begin
        n_reg   <= len_pop ? bus.len_fifo_data : '0;
        seq_reg <= seq_in;
        cnt     <= '0;
        crc     <= 16'hFFFF;
      end else begin
        if (fire && (state == S_LEN || state == S_SEQ || state == S_PAYLOAD)) begin
          crc <= crc_step(crc, tx_data_c);
        end
        if (ring_rd_c) cnt <= cnt + LEN_BITS'(1);
      end
    end
  end

`ifdef FRAME_TX_STATS_EN
  // Completed-frame counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count <= 16'h0000;
    end else if (state == S_SYNC && fire) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_tx.sv
// tb_frame_tx: self-checking bench for frame_tx.
//
// The bench models the length FIFO and payload ring as queues, captures
// every transferred byte, and compares against frames built from the
// frame-format rules with a bitwise reflected CRC-16 (poly 0x8408).
module tb_frame_tx;
  localparam int LEN_BITS    = 8;
  localparam int MAX_PAYLOAD = 59;

  typedef logic [7:0] bq_t [$];

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] seq_in;
  logic       ack_req;
  logic       overflow_err;
`ifdef FRAME_TX_STATS_EN
  logic [15:0] frame_count;
`endif

  frame_tx_if #(.LEN_BITS(LEN_BITS)) bus();

  frame_tx #(
    .LEN_BITS   (LEN_BITS),
    .MAX_PAYLOAD(MAX_PAYLOAD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.master),
    .seq_in      (seq_in),
    .ack_req     (ack_req),
    .overflow_err(overflow_err)
`ifdef FRAME_TX_STATS_EN
    ,
    .frame_count (frame_count)
`endif
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         len_pops, ring_pops, ovf_pulses;
  bq_t        lenq, ringq, heldq, capq, expq, empty_q;
  int         stamps[$];
  int         ready_mode = 0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] ack0 [5] = '{8'h05, 8'h10, 8'h9E, 8'h81, 8'h7E};

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] refCrc(input bq_t q);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (q[i]) begin
      c = c ^ {8'h00, q[i]};
      for (int b = 0; b < 8; b++) begin
        c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
      end
    end
    return c;
  endfunction

  function automatic bq_t randPayload(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic buildExpected(input logic [3:0] seq, input bq_t pl);
    bq_t fr;
    logic [15:0] c;
    fr.push_back(8'(pl.size() + 5));
    fr.push_back({4'h1, seq});
    foreach (pl[i]) fr.push_back(pl[i]);
    c = refCrc(fr);
    fr.push_back(c[15:8]);
    fr.push_back(c[7:0]);
    fr.push_back(8'h7E);
    foreach (fr[i]) expq.push_back(fr[i]);
  endtask

  task automatic drive();
    bus.len_fifo_empty = (lenq.size() == 0);
    bus.len_fifo_data  = (lenq.size() != 0) ? lenq[0] : 8'h00;
    bus.ring_empty     = (ringq.size() == 0);
    bus.ring_data      = (ringq.size() != 0) ? ringq[0] : 8'h00;
  endtask

  // Queue one response: length entry, payload to ring (or held back), and
  // the expected frame when it is not oversize.
  task automatic applyStimulus(input bq_t pl, input bit hold);
    lenq.push_back(8'(pl.size()));
    foreach (pl[i]) begin
      if (hold) heldq.push_back(pl[i]);
      else      ringq.push_back(pl[i]);
    end
    if (pl.size() <= MAX_PAYLOAD) buildExpected(seq_in, pl);
    drive();
  endtask

  // One clock: observe at the falling edge, apply pops and new inputs 1 time
  // unit after the rising edge.
  task automatic tick();
    bit do_len, do_ring;
    @(negedge clk);
    if (prev_stall) begin
      checkOutput("stall tx_valid", bus.tx_valid, 1);
      checkOutput("stall tx_data", bus.tx_data, prev_data);
    end
    prev_stall = bus.tx_valid && !bus.tx_ready && !rst;
    prev_data  = bus.tx_data;
    if (bus.tx_valid && bus.tx_ready && !rst) begin
      capq.push_back(bus.tx_data);
      stamps.push_back(cyc);
    end
    do_len  = bus.len_fifo_rd_en;
    do_ring = bus.ring_rd_en;
    if (do_len)       len_pops++;
    if (do_ring)      ring_pops++;
    if (overflow_err) ovf_pulses++;
    @(posedge clk);
    #1;
    cyc++;
    if (do_len) begin
      checkOutput("len pop nonempty", lenq.size() != 0, 1);
      if (lenq.size() != 0) void'(lenq.pop_front());
    end
    if (do_ring) begin
      checkOutput("ring pop nonempty", ringq.size() != 0, 1);
      if (ringq.size() != 0) void'(ringq.pop_front());
    end
    ack_req = 1'b0;
    if (ready_mode == 1)      bus.tx_ready = ~bus.tx_ready;
    else if (ready_mode == 2) bus.tx_ready = 1'($urandom_range(0, 1));
    drive();
  endtask

  task automatic clearSection();
    capq.delete();
    expq.delete();
    stamps.delete();
    len_pops   = 0;
    ring_pops  = 0;
    ovf_pulses = 0;
  endtask

  task automatic runUntil(input string tag, input int cnt, input int budget);
    int k;
    k = 0;
    while (capq.size() < cnt && k < budget) begin
      tick();
      k++;
    end
    checkOutput($sformatf("%s completes", tag), capq.size() >= cnt, 1);
    repeat (8) tick();
  endtask

  task automatic compareFrames(input string tag);
    int m;
    checkOutput($sformatf("%s byte count", tag), capq.size(), expq.size());
    m = (capq.size() < expq.size()) ? capq.size() : expq.size();
    for (int i = 0; i < m; i++) begin
      checkOutput($sformatf("%s byte %0d", tag, i), capq[i], expq[i]);
    end
  endtask

  initial begin
    int total;
    int sizes[4];
    int k;

    rst          = 1'b1;
    seq_in       = 4'h0;
    ack_req      = 1'b0;
    bus.tx_ready = 1'b1;
    drive();
    clearSection();
    repeat (3) tick();
    checkOutput("reset tx_valid", bus.tx_valid, 0);
    checkOutput("reset tx_data", bus.tx_data, 0);
    checkOutput("reset len_rd_en", bus.len_fifo_rd_en, 0);
    checkOutput("reset ring_rd_en", bus.ring_rd_en, 0);
    checkOutput("reset overflow_err", overflow_err, 0);
    rst = 1'b0;
    tick();

    // Acknowledge frame with seq 0.
    clearSection();
    seq_in  = 4'h0;
    ack_req = 1'b1;
    buildExpected(4'h0, empty_q);
    tick();
    runUntil("ack", 5, 50);
    compareFrames("ack");
    for (int i = 0; i < 5; i++) checkOutput($sformatf("ack const %0d", i), capq[i], ack0[i]);
    checkOutput("ack len pops", len_pops, 0);
    checkOutput("ack ring pops", ring_pops, 0);

    // Three-byte response, seq 5.
    clearSection();
    seq_in = 4'h5;
    applyStimulus('{8'hAA, 8'hBB, 8'hCC}, 1'b0);
    runUntil("resp", 8, 100);
    compareFrames("resp");
    checkOutput("resp LEN", capq[0], 8'h08);
    checkOutput("resp SEQ", capq[1], 8'h15);
    checkOutput("resp len pops", len_pops, 1);
    checkOutput("resp ring pops", ring_pops, 3);

    // Same response with tx_ready toggling every cycle.
    clearSection();
    ready_mode = 1;
    applyStimulus('{8'hAA, 8'hBB, 8'hCC}, 1'b0);
    runUntil("bp", 8, 200);
    compareFrames("bp");
    ready_mode   = 0;
    bus.tx_ready = 1'b1;

    // Ring underflow: second payload byte arrives 10 cycles late.
    clearSection();
    seq_in = 4'($urandom);
    applyStimulus(randPayload(2), 1'b1);
    ringq.push_back(heldq.pop_front());
    drive();
    k = 0;
    while (ring_pops < 1 && k < 50) begin
      tick();
      k++;
    end
    checkOutput("underflow first pop", ring_pops, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput($sformatf("underflow gap %0d", i), bus.tx_valid, 0);
    end
    ringq.push_back(heldq.pop_front());
    drive();
    runUntil("underflow", 7, 100);
    compareFrames("underflow");

    // Oversize response discarded, then a queued 2-byte frame.
    clearSection();
    seq_in = 4'($urandom);
    applyStimulus(randPayload(60), 1'b0);
    applyStimulus(randPayload(2), 1'b0);
    runUntil("oversize", 7, 300);
    compareFrames("oversize");
    checkOutput("oversize ring pops", ring_pops, 62);
    checkOutput("oversize len pops", len_pops, 2);
    checkOutput("oversize overflow pulses", ovf_pulses, 1);

    // Back-to-back 1-byte frames: n+6 cycles between frame starts.
    clearSection();
    seq_in = 4'($urandom);
    applyStimulus(randPayload(1), 1'b0);
    applyStimulus(randPayload(1), 1'b0);
    runUntil("b2b", 12, 100);
    compareFrames("b2b");
    checkOutput("b2b frame period", stamps[6] - stamps[0], 7);

    // ack_req in the same cycle as a length pop stays pending.
    clearSection();
    seq_in = 4'($urandom);
    applyStimulus(randPayload(1), 1'b0);
    ack_req = 1'b1;
    buildExpected(seq_in, empty_q);
    runUntil("ack+pop", 11, 100);
    compareFrames("ack+pop");
    checkOutput("ack+pop len pops", len_pops, 1);

    // Boundary payload sizes under random backpressure.
    clearSection();
    ready_mode = 2;
    seq_in     = 4'($urandom);
    sizes[0]   = 0;
    sizes[1]   = MAX_PAYLOAD;
    sizes[2]   = $urandom_range(1, MAX_PAYLOAD);
    sizes[3]   = $urandom_range(1, MAX_PAYLOAD);
    total      = 0;
    foreach (sizes[i]) begin
      applyStimulus(randPayload(sizes[i]), 1'b0);
      total += sizes[i] + 5;
    end
    runUntil("random", total, 3000);
    compareFrames("random");
    checkOutput("random ring pops", ring_pops, total - 20);
    ready_mode   = 0;
    bus.tx_ready = 1'b1;
    drive();

    // Reset in the middle of a 3-byte payload.
    clearSection();
    seq_in = 4'h3;
    applyStimulus(randPayload(3), 1'b0);
    k = 0;
    while (capq.size() < 3 && k < 50) begin
      tick();
      k++;
    end
    rst        = 1'b1;
    prev_stall = 1'b0;
    #1;
    checkOutput("midreset tx_valid", bus.tx_valid, 0);
    checkOutput("midreset tx_data", bus.tx_data, 0);
    checkOutput("midreset ring_rd_en", bus.ring_rd_en, 0);
    checkOutput("midreset len_rd_en", bus.len_fifo_rd_en, 0);
    checkOutput("midreset overflow_err", overflow_err, 0);
    ringq.delete();
    lenq.delete();
    drive();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    clearSection();
    seq_in  = 4'($urandom);
    ack_req = 1'b1;
    buildExpected(seq_in, empty_q);
    tick();
    runUntil("post-reset ack", 5, 50);
    compareFrames("post-reset ack");
    checkOutput("post-reset LEN", capq[0], 8'h05);
    checkOutput("post-reset SEQ high nibble", capq[1][7:4], 4'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
